leiwand_rv32_wb_arbiter: RTL and testbench
==========================================

# leiwand_rv32_wb_arbiter

Two-master Wishbone (pipelined) arbiter that shares one slave port between the `leiwand_rv32_core` instruction/data master (M0) and a second master (M1, e.g. debug loader or DMA). The arbiter uses round-robin grant and holds the grant for the full `cyc` burst. A per-grant watchdog aborts a hung slave access with an error pulse. It sits between the core's `o_cyc/o_stb/...` port and the memory/peripheral interconnect.

## Interface
- `MEM_WIDTH`, 32, address and data width.
- `TIMEOUT_CYCLES`, 255, cycles without `i_ack` before the current grant is aborted; legal range 2..65535.

- `i_clk`  in  1  single clock; all logic on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we`  in  1 each  M0 Wishbone control.
- `i_m0_addr`, `i_m0_data`  in  MEM_WIDTH  M0 address and write data.
- `o_m0_ack`, `o_m0_stall`, `o_m0_err`  out  1 each  M0 handshake returns.
- `o_m0_data`  out  MEM_WIDTH  M0 read data.
- `i_m1_*` / `o_m1_*`: same set, widths and meanings for M1.
- `o_cyc`, `o_stb`, `o_we`  out  1 each  slave-side control.
- `o_addr`, `o_data`  out  MEM_WIDTH  slave-side address and write data.
- `i_ack`, `i_stall`  in  1 each  slave handshake.
- `i_data`  in  MEM_WIDTH  slave read data.
- `o_grant`  out  2  one-hot current owner; 00 when idle.

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Registers: `state`, `last_grant` (1 bit), watchdog counter (16 bit).
- IDLE behaviour:
  - Only one `i_mX_cyc` high: go to that master's GRANT state.
  - Both high: grant the master that is not `last_grant`.
  - `last_grant` resets to 1, so M0 wins the first tie.
- On entry to GRANTx, `last_grant` is set to x.
- Slave-side outputs while in GRANTx:
  - `o_cyc`, `o_stb`, `o_we`, `o_addr` and `o_data` are driven combinationally from master x.
  - In IDLE all slave-side outputs are 0.
- Returns to the granted master: `o_mx_ack = i_ack`, `o_mx_stall = i_stall`, `o_mx_data = i_data`.
- Returns to a master that is not granted:
  - `ack` = 0, `err` = 0, `data` = 0.
  - `stall` = its own `i_mY_cyc`. A requesting master sees stall; an idle master sees `stall` = 0, which is required so the core's bus-ready logic can start a cycle.
- Release: in GRANTx, when `i_mx_cyc` is low:
  - Next state is GRANTy if `i_my_cyc` is high (handoff with no idle cycle).
  - Otherwise next state is IDLE.
- Watchdog:
  - Cleared on grant entry and on every `i_ack`.
  - Increments each GRANTx cycle without `i_ack`.
  - When the count equals `TIMEOUT_CYCLES-1` with no `i_ack`: `o_mx_err` = 1 for that one cycle, and the next state is IDLE, or GRANTy if y requests.
  - `i_ack` arriving after the abort is not forwarded to anyone.
- Simultaneous `i_ack` and timeout in the same cycle: the ack wins, with no err and no abort.
- Reset mid-transaction: the next cycle is IDLE, `last_grant` = 1, counter = 0, and the slave side drops `cyc` immediately.

## Timing
- Reset values of outputs:
  - `o_cyc`, `o_stb`, `o_we`, `o_addr`, `o_data`, `o_grant`: 0.
  - `o_mX_ack`, `o_mX_err`, `o_mX_data`: 0.
  - `o_mX_stall` = `i_mX_cyc` (combinational; 0 when the master is idle).
- Grant latency: a request rising in IDLE at cycle N gives `o_grant`/`o_cyc` at cycle N+1. The master sees stall in cycle N and must hold `stb`, `addr` and `data`.
- Ack path is combinational: zero added latency for `ack`, `stall` and `data`.
- Handoff: if x drops `cyc` at cycle N while y requests, y is on the slave port at cycle N+1.
- Timeout: `err` is asserted in the `TIMEOUT_CYCLES`-th consecutive granted cycle without ack. `o_cyc` is 0 (or the other master's) in the following cycle.
- One grant per `cyc` assertion; masters cannot be preempted except by timeout.

## Test plan
- M0 alone, read addr 0x10000000, slave acks one cycle after `stb` with `i_data`=0x00500093 -> `o_grant`=01 one cycle after request; `o_m0_ack`=1 for one cycle with `o_m0_data`=0x00500093; `o_m1_ack`=0, `o_m1_stall`=0.
- Both masters raise `cyc`+`stb` in the same cycle after reset -> M0 granted; `o_m1_stall`=1 until M0 drops `cyc`; M1 on `o_addr` the very next cycle with no IDLE cycle.
- Both request back-to-back single-beat transfers for 6 transactions -> grant sequence 0,1,0,1,0,1; no master starves.
- `TIMEOUT_CYCLES`=8, M1 granted, slave never acks -> `o_m1_err`=1 in the 8th granted cycle only; `o_cyc`=0 the next cycle; a late `i_ack` 2 cycles later gives `o_m0_ack`=`o_m1_ack`=0.
- `i_stall` high for 3 cycles during an M0 write of 0xDEADBEEF to 0x20000004 -> `o_m0_stall` mirrors it exactly; `o_data` holds 0xDEADBEEF throughout; `o_we`=1.
- `i_rst` asserted while in GRANT1 mid-access -> next cycle `o_cyc`=0 and `o_grant`=00; after release a simultaneous request grants M0 first.

Source files
------------

// File: rtl/leiwand_rv32_wb_arbiter.sv
// leiwand_rv32_wb_arbiter
// Two-master pipelined Wishbone arbiter. M0 (core) and M1 (debug/DMA) share
// one slave port. Round-robin on ties, the grant is held for the whole cyc
// burst, and a per-grant watchdog aborts a slave that never acks.
//
// Ports:
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_mX_cyc/stb/we/addr/data   : master X request side
//   o_mX_ack/stall/err/data     : master X returns
//   o_cyc/stb/we/addr/data      : slave request side
//   i_ack/stall/data            : slave returns
//   o_grant                     : one-hot current owner (00 when idle)
module leiwand_rv32_wb_arbiter #(
  parameter int unsigned MEM_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_m0_cyc,
  input  logic                 i_m0_stb,
  input  logic                 i_m0_we,
  input  logic [MEM_WIDTH-1:0] i_m0_addr,
  input  logic [MEM_WIDTH-1:0] i_m0_data,
  output logic                 o_m0_ack,
  output logic                 o_m0_stall,
  output logic                 o_m0_err,
  output logic [MEM_WIDTH-1:0] o_m0_data,
  input  logic                 i_m1_cyc,
  input  logic                 i_m1_stb,
  input  logic                 i_m1_we,
  input  logic [MEM_WIDTH-1:0] i_m1_addr,
  input  logic [MEM_WIDTH-1:0] i_m1_data,
  output logic                 o_m1_ack,
  output logic                 o_m1_stall,
  output logic                 o_m1_err,
  output logic [MEM_WIDTH-1:0] o_m1_data,
  output logic                 o_cyc,
  output logic                 o_stb,
  output logic                 o_we,
  output logic [MEM_WIDTH-1:0] o_addr,
  output logic [MEM_WIDTH-1:0] o_data,
  input  logic                 i_ack,
  input  logic                 i_stall,
  input  logic [MEM_WIDTH-1:0] i_data,
  output logic [1:0]           o_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  // Count value reached in the TIMEOUT_CYCLES-th granted cycle without ack.
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_s;

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wdog_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
    end
  end

  // Next-state logic: arbitration, release/handoff, watchdog abort.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    timeout_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          // Tie goes to whoever was not served last.
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (i_m0_cyc) begin
          state_d = GRANT0;
        end else if (i_m1_cyc) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        // An ack in the limit cycle wins over the abort.
        timeout_s = (wdog_q == WDOG_LIMIT) && !i_ack;
        if (!i_m0_cyc || timeout_s) begin
          state_d = i_m1_cyc ? GRANT1 : IDLE;
        end else begin
          state_d = GRANT0;
        end
      end
      GRANT1: begin
        timeout_s = (wdog_q == WDOG_LIMIT) && !i_ack;
        if (!i_m1_cyc || timeout_s) begin
          state_d = i_m0_cyc ? GRANT0 : IDLE;
        end else begin
          state_d = GRANT1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog restarts on every new grant (including handoff) and on ack.
    if (state_d == IDLE) begin
      wdog_d = 16'd0;
    end else if (state_d != state_q) begin
      wdog_d       = 16'd0;
      last_grant_d = (state_d == GRANT1);
    end else if (i_ack) begin
      wdog_d = 16'd0;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  // Combinational bus steering; a non-granted master sees stall = its own cyc.
  always_comb begin
    o_cyc      = 1'b0;
    o_stb      = 1'b0;
    o_we       = 1'b0;
    o_addr     = {MEM_WIDTH{1'b0}};
    o_data     = {MEM_WIDTH{1'b0}};
    o_grant    = 2'b00;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_data  = {MEM_WIDTH{1'b0}};
    o_m0_stall = i_m0_cyc;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_data  = {MEM_WIDTH{1'b0}};
    o_m1_stall = i_m1_cyc;

    case (state_q)
      IDLE: begin
        o_grant = 2'b00;
      end
      GRANT0: begin
        o_grant    = 2'b01;
        o_cyc      = i_m0_cyc;
        o_stb      = i_m0_stb;
        o_we       = i_m0_we;
        o_addr     = i_m0_addr;
        o_data     = i_m0_data;
        o_m0_ack   = i_ack;
        o_m0_stall = i_stall;
        o_m0_data  = i_data;
        o_m0_err   = timeout_s;
      end
      GRANT1: begin
        o_grant    = 2'b10;
        o_cyc      = i_m1_cyc;
        o_stb      = i_m1_stb;
        o_we       = i_m1_we;
        o_addr     = i_m1_addr;
        o_data     = i_m1_data;
        o_m1_ack   = i_ack;
        o_m1_stall = i_stall;
        o_m1_data  = i_data;
        o_m1_err   = timeout_s;
      end
      default: begin
        o_grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_arbiter.sv
// Self-checking bench for leiwand_rv32_wb_arbiter (TIMEOUT_CYCLES = 8).
// Expected acks are queued when stimulus is driven and popped by a monitor
// whenever either master sees an ack.
module tb_leiwand_rv32_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_cyc, i_m0_stb, i_m0_we;
  logic [31:0] i_m0_addr, i_m0_data;
  logic        o_m0_ack, o_m0_stall, o_m0_err;
  logic [31:0] o_m0_data;
  logic        i_m1_cyc, i_m1_stb, i_m1_we;
  logic [31:0] i_m1_addr, i_m1_data;
  logic        o_m1_ack, o_m1_stall, o_m1_err;
  logic [31:0] o_m1_data;
  logic        o_cyc, o_stb, o_we;
  logic [31:0] o_addr, o_data;
  logic        i_ack, i_stall;
  logic [31:0] i_data;
  logic [1:0]  o_grant;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];   // {master id, read data}

  always #5 i_clk = ~i_clk;

  leiwand_rv32_wb_arbiter #(.MEM_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data),
    .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data),
    .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
    .i_ack(i_ack), .i_stall(i_stall), .i_data(i_data), .o_grant(o_grant)
  );

  // Scoreboard monitor: every forwarded ack must match the next queued entry.
  always @(negedge i_clk) begin
    logic [32:0] e;
    if (o_m0_ack === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL sb_m0_unexpected: got m0 ack data=%h, expected no ack", o_m0_data);
      end else begin
        e = exp_q.pop_front();
        if ({1'b0, o_m0_data} !== e) begin
          bad++; $display("FAIL sb_m0: got master=0 data=%h, expected master=%0d data=%h", o_m0_data, e[32], e[31:0]);
        end
      end
    end
    if (o_m1_ack === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL sb_m1_unexpected: got m1 ack data=%h, expected no ack", o_m1_data);
      end else begin
        e = exp_q.pop_front();
        if ({1'b1, o_m1_data} !== e) begin
          bad++; $display("FAIL sb_m1: got master=1 data=%h, expected master=%0d data=%h", o_m1_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m0_we = 1'b0; i_m0_addr = 32'h0; i_m0_data = 32'h0;
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_m1_we = 1'b0; i_m1_addr = 32'h0; i_m1_data = 32'h0;
    i_ack = 1'b0; i_stall = 1'b0; i_data = 32'h0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst = 1'b1; i_m0_cyc = 1'b1;
    tick(); tick(); #1;
    total++;
    if ({o_cyc, o_stb, o_we, o_grant} !== 5'b0 || o_addr !== 32'h0 || o_data !== 32'h0) begin
      bad++; $display("FAIL reset_slave: got cyc=%b stb=%b we=%b grant=%b addr=%h data=%h, expected all 0", o_cyc, o_stb, o_we, o_grant, o_addr, o_data);
    end
    total++;
    if (o_m0_stall !== 1'b1 || o_m1_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got m0_stall=%b m1_stall=%b, expected 1 0", o_m0_stall, o_m1_stall);
    end
    total++;
    if ({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err} !== 4'b0 || o_m0_data !== 32'h0 || o_m1_data !== 32'h0) begin
      bad++; $display("FAIL reset_returns: got ack/err=%b%b%b%b d0=%h d1=%h, expected 0", o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_m0_data, o_m1_data);
    end
    i_m0_cyc = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_m0_read();
    tick();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 32'h1000_0000; #1;
    total++;
    if (o_grant !== 2'b00 || o_m0_stall !== 1'b1 || o_cyc !== 1'b0) begin
      bad++; $display("FAIL m0_req: got grant=%b stall=%b cyc=%b, expected 00 1 0", o_grant, o_m0_stall, o_cyc);
    end
    tick(); #1;
    total++;
    if (o_grant !== 2'b01 || o_cyc !== 1'b1 || o_stb !== 1'b1 || o_we !== 1'b0 || o_addr !== 32'h1000_0000) begin
      bad++; $display("FAIL m0_grant: got grant=%b cyc=%b stb=%b we=%b addr=%h, expected 01 1 1 0 10000000", o_grant, o_cyc, o_stb, o_we, o_addr);
    end
    total++;
    if (o_m0_stall !== 1'b0 || o_m1_stall !== 1'b0) begin
      bad++; $display("FAIL m0_grant_stall: got m0=%b m1=%b, expected 0 0", o_m0_stall, o_m1_stall);
    end
    tick();
    i_m0_stb = 1'b0; i_ack = 1'b1; i_data = 32'h0050_0093;
    exp_q.push_back({1'b0, 32'h0050_0093}); #1;
    total++;
    if (o_m0_ack !== 1'b1 || o_m0_data !== 32'h0050_0093 || o_m1_ack !== 1'b0 || o_m1_stall !== 1'b0) begin
      bad++; $display("FAIL m0_ack: got ack=%b data=%h m1_ack=%b m1_stall=%b, expected 1 00500093 0 0", o_m0_ack, o_m0_data, o_m1_ack, o_m1_stall);
    end
    tick();
    i_ack = 1'b0; i_data = 32'h0; i_m0_cyc = 1'b0; #1;
    total++;
    if (o_m0_ack !== 1'b0) begin
      bad++; $display("FAIL m0_ack_single: got ack=%b, expected 0", o_m0_ack);
    end
    tick(); #1;
    total++;
    if (o_grant !== 2'b00 || o_cyc !== 1'b0) begin
      bad++; $display("FAIL m0_release: got grant=%b cyc=%b, expected 00 0", o_grant, o_cyc);
    end
  endtask

  task automatic test_tie_handoff();
    do_reset(); clear_inputs();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 32'h1000_0100;
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 32'h3000_0000;
    tick(); #1;
    total++;
    if (o_grant !== 2'b01 || o_addr !== 32'h1000_0100 || o_m1_stall !== 1'b1) begin
      bad++; $display("FAIL tie_m0_first: got grant=%b addr=%h m1_stall=%b, expected 01 10000100 1", o_grant, o_addr, o_m1_stall);
    end
    tick();
    i_m0_stb = 1'b0; i_ack = 1'b1; i_data = 32'h1111_1111;
    exp_q.push_back({1'b0, 32'h1111_1111}); #1;
    total++;
    if (o_m1_stall !== 1'b1 || o_m1_ack !== 1'b0 || o_m0_ack !== 1'b1) begin
      bad++; $display("FAIL tie_m0_ack: got m0_ack=%b m1_ack=%b m1_stall=%b, expected 1 0 1", o_m0_ack, o_m1_ack, o_m1_stall);
    end
    tick();
    i_ack = 1'b0; i_m0_cyc = 1'b0; #1;
    total++;
    if (o_m1_stall !== 1'b1 || o_grant !== 2'b01) begin
      bad++; $display("FAIL tie_m0_drop: got grant=%b m1_stall=%b, expected 01 1", o_grant, o_m1_stall);
    end
    tick(); #1;
    total++;
    if (o_grant !== 2'b10 || o_cyc !== 1'b1 || o_addr !== 32'h3000_0000 || o_m1_stall !== 1'b0) begin
      bad++; $display("FAIL handoff_no_idle: got grant=%b cyc=%b addr=%h m1_stall=%b, expected 10 1 30000000 0", o_grant, o_cyc, o_addr, o_m1_stall);
    end
    tick();
    i_m1_stb = 1'b0; i_ack = 1'b1; i_data = 32'h2222_2222;
    exp_q.push_back({1'b1, 32'h2222_2222}); #1;
    tick();
    i_ack = 1'b0; i_m1_cyc = 1'b0;
    tick(); #1;
    total++;
    if (o_grant !== 2'b00) begin
      bad++; $display("FAIL tie_idle: got grant=%b, expected 00", o_grant);
    end
  endtask

  task automatic test_round_robin();
    logic g;
    logic [1:0] eg;
    do_reset(); clear_inputs();
    i_m0_addr = 32'h1000_0200; i_m1_addr = 32'h3000_0200;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g  = (k % 2) == 1;
      eg = g ? 2'b10 : 2'b01;
      tick();
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
      i_ack = 1'b1; i_data = 32'hA000_0000 + 32'(k);
      exp_q.push_back({g, i_data}); #1;
      total++;
      if (o_grant !== eg || o_addr !== (g ? 32'h3000_0200 : 32'h1000_0200)) begin
        bad++; $display("FAIL rr_grant[%0d]: got grant=%b addr=%h, expected grant=%b", k, o_grant, o_addr, eg);
      end
      tick();
      i_ack = 1'b0;
      if (g) begin
        i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
      end else begin
        i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
      end
      #1;
      total++;
      if ((g ? o_m0_stall : o_m1_stall) !== 1'b1) begin
        bad++; $display("FAIL rr_waiting_stall[%0d]: got stall=%b, expected 1", k, g ? o_m0_stall : o_m1_stall);
      end
    end
    tick(); clear_inputs();
    tick(); #1;
    total++;
    if (o_grant !== 2'b00) begin
      bad++; $display("FAIL rr_idle: got grant=%b, expected 00", o_grant);
    end
  endtask

  task automatic test_timeout();
    do_reset(); clear_inputs();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 32'h4000_0000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) i_m1_stb = 1'b0;
      #1;
      total++;
      if (o_grant !== 2'b10 || o_m1_err !== (c == 8) || o_m0_err !== 1'b0) begin
        bad++; $display("FAIL timeout_cycle[%0d]: got grant=%b m1_err=%b m0_err=%b, expected 10 %0d 0", c, o_grant, o_m1_err, o_m0_err, (c == 8));
      end
    end
    tick();
    i_m1_cyc = 1'b0; #1;
    total++;
    if (o_cyc !== 1'b0 || o_grant !== 2'b00 || o_m1_err !== 1'b0) begin
      bad++; $display("FAIL timeout_abort: got cyc=%b grant=%b err=%b, expected 0 00 0", o_cyc, o_grant, o_m1_err);
    end
    tick();
    i_ack = 1'b1; i_data = 32'hBAD0_0000; #1;
    total++;
    if (o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0) begin
      bad++; $display("FAIL timeout_late_ack: got m0_ack=%b m1_ack=%b, expected 0 0", o_m0_ack, o_m1_ack);
    end
    tick();
    i_ack = 1'b0; i_data = 32'h0;
    // Ack landing exactly in the limit cycle must win over the abort.
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 32'h1000_0300;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) i_m0_stb = 1'b0;
      if (c == 8) begin
        i_ack = 1'b1; i_data = 32'hC0DE_0008;
        exp_q.push_back({1'b0, 32'hC0DE_0008});
      end
      #1;
      total++;
      if (o_grant !== 2'b01 || o_m0_err !== 1'b0 || o_m0_ack !== (c == 8)) begin
        bad++; $display("FAIL ack_vs_timeout[%0d]: got grant=%b err=%b ack=%b, expected 01 0 %0d", c, o_grant, o_m0_err, o_m0_ack, (c == 8));
      end
    end
    tick();
    i_ack = 1'b0; #1;
    total++;
    if (o_grant !== 2'b01 || o_m0_err !== 1'b0) begin
      bad++; $display("FAIL ack_vs_timeout_hold: got grant=%b err=%b, expected 01 0", o_grant, o_m0_err);
    end
    tick();
    i_m0_cyc = 1'b0;
    tick();
  endtask

  task automatic test_stall_write();
    clear_inputs();
    tick();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b1;
    i_m0_addr = 32'h2000_0004; i_m0_data = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      i_stall = (c <= 3); #1;
      total++;
      if (o_m0_stall !== i_stall || o_data !== 32'hDEAD_BEEF || o_we !== 1'b1 || o_addr !== 32'h2000_0004 || o_grant !== 2'b01) begin
        bad++; $display("FAIL stall_write[%0d]: got stall=%b data=%h we=%b addr=%h grant=%b, expected stall=%b DEADBEEF 1 20000004 01", c, o_m0_stall, o_data, o_we, o_addr, o_grant, i_stall);
      end
    end
    tick();
    i_m0_stb = 1'b0; i_ack = 1'b1; i_data = 32'h0;
    exp_q.push_back({1'b0, 32'h0}); #1;
    total++;
    if (o_m0_ack !== 1'b1 || o_m1_stall !== 1'b0) begin
      bad++; $display("FAIL stall_write_ack: got ack=%b m1_stall=%b, expected 1 0", o_m0_ack, o_m1_stall);
    end
    tick();
    i_ack = 1'b0; i_m0_cyc = 1'b0; i_m0_we = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    tick();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 32'h5000_0000;
    tick(); #1;
    total++;
    if (o_grant !== 2'b10) begin
      bad++; $display("FAIL rst_pre_grant1: got grant=%b, expected 10", o_grant);
    end
    tick();
    i_m1_stb = 1'b0; i_rst = 1'b1;
    tick(); #1;
    total++;
    if (o_cyc !== 1'b0 || o_grant !== 2'b00) begin
      bad++; $display("FAIL rst_mid_drop: got cyc=%b grant=%b, expected 0 00", o_cyc, o_grant);
    end
    i_rst = 1'b0; i_m1_cyc = 1'b0;
    tick();
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
    tick(); #1;
    total++;
    if (o_grant !== 2'b01) begin
      bad++; $display("FAIL rst_tie_m0: got grant=%b, expected 01", o_grant);
    end
    tick(); clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    i_rst = 1'b1;
    test_reset();
    test_m0_read();
    test_tie_handoff();
    test_round_robin();
    test_timeout();
    test_stall_write();
    test_reset_mid();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d pending acks, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
